// File: rtl/clk_phase_gen.sv
// Single-clock enable generator: one pulse per domain at a programmable phase within a
// programmable period, with run/halt/single-step control and a completed-period counter.
module clk_phase_gen #(
    parameter int N_DOMAINS = 4,
    parameter int DIV_W     = 4,
    parameter bit START_RUN = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DIV_W-1:0]           div_cfg,
    input  logic [N_DOMAINS*DIV_W-1:0] phase_cfg,
    input  logic                       run_req,
    input  logic                       halt_req,
    input  logic                       step_req,
    output logic [N_DOMAINS-1:0]       phase_en,
    output logic                       tick,
    output logic                       halted,
    output logic                       cfg_err,
    output logic [31:0]                period_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    localparam state_e RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

    typedef logic [N_DOMAINS-1:0][DIV_W-1:0] phase_arr_t;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_lat_q, div_lat_d;
    phase_arr_t         ph_lat_q, ph_lat_d;
    phase_arr_t         ph_cfg;
    logic               halt_pend_q, halt_pend_d;
    logic               run_seen_q, run_seen_d;
    logic [31:0]        period_cnt_q, period_cnt_d;

    logic [DIV_W-1:0]   div_eff;
    logic               active;

    // Field i of phase_cfg lands in element i of the packed array.
    assign ph_cfg  = phase_cfg;
    assign div_eff = (div_lat_q == '0) ? DIV_W'(1) : div_lat_q;
    assign active  = (state_q == ST_RUN) || (state_q == ST_STEP);

    // Outputs depend only on registered state, so they are stable for the whole cycle.
    always_comb begin
        phase_en = '0;
        cfg_err  = (div_lat_q == '0);
        for (int i = 0; i < N_DOMAINS; i++) begin
            phase_en[i] = active && (cnt_q == ph_lat_q[i]);
            if (ph_lat_q[i] >= div_eff) begin
                cfg_err = 1'b1;
            end
        end
    end

    assign tick       = active && (cnt_q == div_eff - DIV_W'(1));
    assign halted     = (state_q == ST_HALT);
    assign period_cnt = period_cnt_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned
    // (which would infer a latch); blocking '=' is correct here because this is combinational.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_lat_d    = div_lat_q;
        ph_lat_d     = ph_lat_q;
        halt_pend_d  = halt_pend_q;
        run_seen_d   = run_seen_q;
        period_cnt_d = period_cnt_q;

        // Period bookkeeping shared by RUN and STEP; config is only sampled at period start.
        if (active) begin
            if (tick) begin
                cnt_d        = '0;
                period_cnt_d = period_cnt_q + 32'd1;
                div_lat_d    = div_cfg;
                ph_lat_d     = ph_cfg;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    if (halt_pend_q || halt_req) begin
                        state_d = ST_HALT;
                    end
                    halt_pend_d = 1'b0;
                end else if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
            end
            ST_HALT: begin
                cnt_d       = '0;
                div_lat_d   = div_cfg;
                ph_lat_d    = ph_cfg;
                halt_pend_d = 1'b0;
                run_seen_d  = 1'b0;
                if (run_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // A run request anywhere in the stepped period converts it into free-running.
                if (tick) begin
                    state_d    = (run_seen_q || run_req) ? ST_RUN : ST_HALT;
                    run_seen_d = 1'b0;
                end else begin
                    run_seen_d = run_seen_q || run_req;
                end
            end
            default: begin
                state_d = ST_HALT;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update together on the edge;
    // reset also captures the live configuration so the first period is already valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            div_lat_q    <= div_cfg;
            ph_lat_q     <= ph_cfg;
            halt_pend_q  <= 1'b0;
            run_seen_q   <= 1'b0;
            period_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_lat_q    <= div_lat_d;
            ph_lat_q     <= ph_lat_d;
            halt_pend_q  <= halt_pend_d;
            run_seen_q   <= run_seen_d;
            period_cnt_q <= period_cnt_d;
        end
    end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Scoreboard bench for clk_phase_gen: two instances (start in RUN / start in HALT) share stimulus;
// a period-position model predicts each cycle's outputs and a monitor compares them.
module tb_clk_phase_gen;

    localparam int N = 4;
    localparam int W = 4;
    localparam int M_RUN  = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;

    typedef struct packed {
        logic [N-1:0] pe;
        logic         tk;
        logic         hl;
        logic         ce;
        logic [31:0]  pc;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } ent_t;

    logic           clock = 1'b0;
    logic           reset;
    logic [W-1:0]   div_cfg;
    logic [N*W-1:0] phase_cfg;
    logic           run_req, halt_req, step_req;

    logic [N-1:0] pe0, pe1;
    logic         tk0, tk1, hl0, hl1, ce0, ce1;
    logic [31:0]  pc0, pc1;

    always #5 clock = ~clock;

    clk_phase_gen #(.N_DOMAINS(N), .DIV_W(W), .START_RUN(1'b1)) u_run (
        .clock(clock), .reset(reset), .div_cfg(div_cfg), .phase_cfg(phase_cfg),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .phase_en(pe0), .tick(tk0), .halted(hl0), .cfg_err(ce0), .period_cnt(pc0)
    );

    clk_phase_gen #(.N_DOMAINS(N), .DIV_W(W), .START_RUN(1'b0)) u_halt (
        .clock(clock), .reset(reset), .div_cfg(div_cfg), .phase_cfg(phase_cfg),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .phase_en(pe1), .tick(tk1), .halted(hl1), .cfg_err(ce1), .period_cnt(pc1)
    );

    int checks   = 0;
    int failures = 0;
    ent_t exp_q[$];

    // Reference model: where we are in the period, what mode we are in, and the latched config.
    int          m_mode[2];
    int          m_pos[2];
    int          m_div[2];
    int          m_ph[2][N];
    bit          m_hp[2];
    bit          m_rs[2];
    int unsigned m_per[2];

    logic [W-1:0]   cur_d;
    logic [N*W-1:0] cur_p;

    function automatic int plen(int k);
        return (m_div[k] == 0) ? 1 : m_div[k];
    endfunction

    function automatic bit last_cycle(int k);
        return (m_mode[k] != M_HALT) && (m_pos[k] == plen(k) - 1);
    endfunction

    function automatic exp_t model_out(int k);
        exp_t o;
        o.pe = '0;
        o.ce = (m_div[k] == 0);
        for (int i = 0; i < N; i++) begin
            if (m_mode[k] != M_HALT && m_pos[k] == m_ph[k][i]) o.pe[i] = 1'b1;
            if (m_ph[k][i] >= plen(k)) o.ce = 1'b1;
        end
        o.tk = last_cycle(k);
        o.hl = (m_mode[k] == M_HALT);
        o.pc = m_per[k];
        return o;
    endfunction

    task automatic load_cfg(int k);
        m_div[k] = int'(div_cfg);
        for (int i = 0; i < N; i++) m_ph[k][i] = int'(phase_cfg[i*W +: W]);
    endtask

    task automatic finish_period(int k);
        m_pos[k] = 0;
        m_per[k] = m_per[k] + 1;
        load_cfg(k);
    endtask

    task automatic model_edge(int k);
        if (!reset) begin
            m_mode[k] = (k == 0) ? M_RUN : M_HALT;
            m_pos[k]  = 0;
            m_hp[k]   = 1'b0;
            m_rs[k]   = 1'b0;
            m_per[k]  = 0;
            load_cfg(k);
        end else begin
            bit last = last_cycle(k);
            case (m_mode[k])
                M_HALT: begin
                    m_pos[k] = 0;
                    m_hp[k]  = 1'b0;
                    m_rs[k]  = 1'b0;
                    load_cfg(k);
                    if (run_req)       m_mode[k] = M_RUN;
                    else if (step_req) m_mode[k] = M_STEP;
                end
                M_RUN: begin
                    if (last) begin
                        finish_period(k);
                        if (m_hp[k] || halt_req) m_mode[k] = M_HALT;
                        m_hp[k] = 1'b0;
                    end else begin
                        m_pos[k] = m_pos[k] + 1;
                        if (halt_req) m_hp[k] = 1'b1;
                    end
                end
                default: begin
                    if (last) begin
                        finish_period(k);
                        m_mode[k] = (m_rs[k] || run_req) ? M_RUN : M_HALT;
                        m_rs[k]   = 1'b0;
                    end else begin
                        m_pos[k] = m_pos[k] + 1;
                        if (run_req) m_rs[k] = 1'b1;
                    end
                end
            endcase
        end
    endtask

    // Drive one clock's inputs, advance the model across that edge, queue the expected outputs.
    task automatic cycle(input bit rst, input logic [W-1:0] d, input logic [N*W-1:0] p,
                         input bit r, input bit h, input bit s);
        ent_t e;
        reset     = rst;
        div_cfg   = d;
        phase_cfg = p;
        run_req   = r;
        halt_req  = h;
        step_req  = s;
        model_edge(0);
        model_edge(1);
        @(posedge clock);
        #1;
        e.a = model_out(0);
        e.b = model_out(1);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, cur_d, cur_p, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input bit r, input bit h, input bit s);
        cycle(1'b1, cur_d, cur_p, r, h, s);
    endtask

    task automatic wait_pos(input int x);
        for (int i = 0; i < 40 && !(m_pos[0] == x && m_mode[0] != M_HALT); i++) idle(1);
        if (!(m_pos[0] == x && m_mode[0] != M_HALT)) begin
            checks++;
            failures++;
            $display("FAIL wait_pos: position %0d not reached, at %0d", x, m_pos[0]);
        end
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, k, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("phase_en",   0, 32'(pe0), 32'(e.a.pe));
                check("tick",       0, 32'(tk0), 32'(e.a.tk));
                check("halted",     0, 32'(hl0), 32'(e.a.hl));
                check("cfg_err",    0, 32'(ce0), 32'(e.a.ce));
                check("period_cnt", 0, pc0,      e.a.pc);
                check("phase_en",   1, 32'(pe1), 32'(e.b.pe));
                check("tick",       1, 32'(tk1), 32'(e.b.tk));
                check("halted",     1, 32'(hl1), 32'(e.b.hl));
                check("cfg_err",    1, 32'(ce1), 32'(e.b.ce));
                check("period_cnt", 1, pc1,      e.b.pc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        cur_d = 4'd4;
        cur_p = 16'h2200;

        // Reset into free-run, then three full periods.
        cycle(1'b0, cur_d, cur_p, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, cur_d, cur_p, 1'b0, 1'b0, 1'b0);
        idle(12);

        // Halt requested mid-period, then resume.
        wait_pos(1);
        pulse(1'b0, 1'b1, 1'b0);
        idle(5);
        pulse(1'b1, 1'b0, 1'b0);
        idle(6);

        // Halt, then one single step.
        pulse(1'b0, 1'b1, 1'b0);
        idle(6);
        pulse(1'b0, 1'b0, 1'b1);
        idle(8);

        // Step with a run request arriving during the stepped period.
        pulse(1'b0, 1'b0, 1'b1);
        idle(1);
        pulse(1'b1, 1'b0, 1'b0);
        idle(8);

        // Divide change mid-period only applies from the next period.
        wait_pos(1);
        cur_d = 4'd2;
        idle(10);

        // Unreachable phase, then divide of zero.
        cur_d = 4'd4;
        cur_p = 16'h5200;
        idle(10);
        cur_d = 4'd0;
        idle(6);

        // Reset in the middle of a period.
        cur_d = 4'd4;
        cur_p = 16'h2200;
        idle(6);
        wait_pos(2);
        cycle(1'b0, cur_d, cur_p, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                cur_d = W'($urandom_range(0, 6));
                for (int i = 0; i < N; i++) cur_p[i*W +: W] = W'($urandom_range(0, 7));
            end
            cycle(($urandom_range(0, 199) != 0), cur_d, cur_p,
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 9) == 0));
        end

        repeat (2) @(negedge clock);
        #1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries never compared", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
